// File: rtl/zipdma_chansched.sv
// Round-robin channel scheduler for the single DMA engine: grants one posted
// descriptor at a time, drives the engine handshake and reports done/err per channel.
module zipdma_chansched #(
    parameter int NCHAN         = 4,
    parameter int ADDRESS_WIDTH = 30,
    parameter int LGDMALENGTH   = 30
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NCHAN-1:0]               i_ch_req,
    input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_ch_src,
    input  logic [NCHAN*ADDRESS_WIDTH-1:0] i_ch_dst,
    input  logic [NCHAN*LGDMALENGTH-1:0]   i_ch_len,
    output logic [NCHAN-1:0]               o_ch_ack,
    output logic [NCHAN-1:0]               o_ch_done,
    output logic [NCHAN-1:0]               o_ch_err,
    input  logic                           i_abort,
    output logic                           o_dma_request,
    output logic                           o_dma_abort,
    input  logic                           i_dma_busy,
    input  logic                           i_dma_err,
    output logic [ADDRESS_WIDTH-1:0]       o_src_addr,
    output logic [ADDRESS_WIDTH-1:0]       o_dst_addr,
    output logic [LGDMALENGTH-1:0]         o_length,
    output logic [$clog2(NCHAN)-1:0]       o_active_chan,
    output logic                           o_busy
);

    localparam int CW = $clog2(NCHAN);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_ABORT} state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            rr_last, rr_last_d;
    logic                     err_seen, err_seen_d;
    logic [NCHAN-1:0]         req_eff;
    logic [CW-1:0]            grant, idx;
    logic                     found;
    logic [ADDRESS_WIDTH-1:0] g_src, g_dst, src_d, dst_d;
    logic [LGDMALENGTH-1:0]   g_len, len_d;
    logic [CW-1:0]            chan_d;
    logic                     req_d, abort_d;
    logic [NCHAN-1:0]         ack_d, done_d, err_d;

    // A zero-length grant returns to IDLE while the client still holds its
    // request during the ack cycle; masking by o_ch_ack avoids a double grant.
    always_comb begin
        req_eff = i_ch_req & ~o_ch_ack;
        grant   = '0;
        found   = 1'b0;
        idx     = rr_last;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            idx = (idx == CW'(NCHAN - 1)) ? '0 : idx + 1'b1;
            if (!found && req_eff[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        g_src = i_ch_src[32'(grant) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
        g_dst = i_ch_dst[32'(grant) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
        g_len = i_ch_len[32'(grant) * LGDMALENGTH +: LGDMALENGTH];
    end

    always_comb begin
        state_d    = state;
        rr_last_d  = rr_last;
        err_seen_d = err_seen;
        chan_d     = o_active_chan;
        src_d      = o_src_addr;
        dst_d      = o_dst_addr;
        len_d      = o_length;
        req_d      = 1'b0;
        abort_d    = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        err_d      = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    src_d        = g_src;
                    dst_d        = g_dst;
                    len_d        = g_len;
                    chan_d       = grant;
                    rr_last_d    = grant;
                    ack_d[grant] = 1'b1;
                    if (g_len == '0) begin
                        done_d[grant] = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (i_abort) begin
                    state_d = S_ABORT;
                    abort_d = 1'b1;
                end else if (i_dma_busy) begin
                    state_d = S_RUN;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!i_dma_busy) begin
                    if (err_seen || i_dma_err)
                        err_d[o_active_chan] = 1'b1;
                    else
                        done_d[o_active_chan] = 1'b1;
                    err_seen_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (i_abort) begin
                    err_seen_d = 1'b0;
                    abort_d    = 1'b1;
                    state_d    = S_ABORT;
                end else if (i_dma_err) begin
                    err_seen_d = 1'b1;
                end
            end
            S_ABORT: begin
                if (!i_dma_busy) begin
                    err_d[o_active_chan] = 1'b1;
                    state_d              = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_last       <= CW'(NCHAN - 1);
            err_seen      <= 1'b0;
            o_active_chan <= '0;
            o_src_addr    <= '0;
            o_dst_addr    <= '0;
            o_length      <= '0;
            o_dma_request <= 1'b0;
            o_dma_abort   <= 1'b0;
            o_ch_ack      <= '0;
            o_ch_done     <= '0;
            o_ch_err      <= '0;
        end else begin
            rr_last       <= rr_last_d;
            err_seen      <= err_seen_d;
            o_active_chan <= chan_d;
            o_src_addr    <= src_d;
            o_dst_addr    <= dst_d;
            o_length      <= len_d;
            o_dma_request <= req_d;
            o_dma_abort   <= abort_d;
            o_ch_ack      <= ack_d;
            o_ch_done     <= done_d;
            o_ch_err      <= err_d;
        end
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: doc/zipdma_chansched.md
Name: zipdma_chansched

Overview:
- Multi-channel scheduler in front of the DMA engine's control interface: request, abort, busy, error, source, destination and length.
- Up to NCHAN software or hardware clients post transfer descriptors.
- The block selects one channel round-robin, issues its descriptor to the DMA engine, and tracks the engine through completion.
- It reports a per-channel done or error pulse, giving exclusive, fair time-sharing of the single DMA datapath.

Parameters:
- NCHAN, 4, number of requesting channels (2..16).
- ADDRESS_WIDTH, 30, byte-address width of src/dst.
- LGDMALENGTH, 30, width of the transfer length field.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ch_req  in  NCHAN  per-channel request level; held by the client until o_ch_ack for that channel.
- i_ch_src  in  NCHAN*ADDRESS_WIDTH  per-channel source byte address; channel k in slice [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- i_ch_dst  in  NCHAN*ADDRESS_WIDTH  per-channel destination byte address; same slicing.
- i_ch_len  in  NCHAN*LGDMALENGTH  per-channel length in bytes.
- o_ch_ack  out  NCHAN  one-cycle pulse: the descriptor has been latched.
- o_ch_done  out  NCHAN  one-cycle pulse: the transfer completed without error.
- o_ch_err  out  NCHAN  one-cycle pulse: the transfer ended in error or abort.
- i_abort  in  1  abort the active transfer.
- o_dma_request  out  1  start request to the DMA engine.
- o_dma_abort  out  1  abort strobe to the DMA engine.
- i_dma_busy  in  1  DMA engine busy.
- i_dma_err  in  1  DMA engine error flag.
- o_src_addr  out  ADDRESS_WIDTH  latched source address.
- o_dst_addr  out  ADDRESS_WIDTH  latched destination address.
- o_length  out  LGDMALENGTH  latched length.
- o_active_chan  out  $clog2(NCHAN)  index of the granted channel.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE; all outputs 0.
  - rr_last=NCHAN-1, so channel 0 wins first.
- State IDLE:
  - When i_ch_req is nonzero, grant g = the first requesting index searching upward (modulo NCHAN) from rr_last+1.
  - On that edge: latch src/dst/len[g] into o_src_addr/o_dst_addr/o_length, set o_active_chan=g and rr_last=g, and pulse o_ch_ack[g] on the next cycle.
  - If len[g]==0: skip the engine, pulse o_ch_done[g] together with o_ch_ack[g], and stay in IDLE.
  - Otherwise go to ISSUE.
  - At most one grant per cycle; requests appearing mid-transfer wait.
- State ISSUE:
  - o_dma_request=1 (registered).
  - When i_dma_busy is seen high: clear o_dma_request and go to RUN.
  - Request-to-busy latency is unbounded; the request is held until busy.
- State RUN:
  - err_seen is set if i_dma_err is ever high while in RUN.
  - On i_dma_busy low: pulse o_ch_err[o_active_chan] if err_seen or i_dma_err, else o_ch_done[o_active_chan]; clear err_seen and return to IDLE.
  - Completion to next grant is at least 1 cycle, since IDLE evaluates on the following cycle.
- Abort:
  - i_abort in ISSUE or RUN: go to ABORT, drop o_dma_request, and drive o_dma_abort=1 for exactly one cycle.
  - State ABORT waits for i_dma_busy low, then pulses o_ch_err[o_active_chan] and goes to IDLE.
  - i_abort in IDLE is ignored.
  - i_abort on the same cycle as completion in RUN: completion wins (done/err reported), no abort strobe.
- Invariants:
  - o_ch_ack, o_ch_done and o_ch_err are each onehot0.
  - Exactly one done or err per ack.
  - Latched descriptor outputs are stable from ack until the done/err pulse.
- Fairness: a continuously requesting channel is granted within NCHAN grants.
- Async reset mid-transfer: all state clears and no completion pulse is produced. The DMA engine is reset by the same system reset.

Test Plan:
- Single request: ch2 req with src=0x1000, dst=0x2000, len=64; engine busy for 10 cycles → o_ch_ack[2] pulse, o_dma_request high until busy, o_src_addr=0x1000, o_ch_done[2] one cycle after busy falls.
- Round-robin: all 4 channels request continuously → grant order 0,1,2,3,0; each ack is followed by exactly one done.
- Zero length: ch1 len=0 → ack[1] and done[1] on the same cycle, o_dma_request never asserted.
- Error: i_dma_err pulsed mid-RUN on ch3 → o_ch_err[3] pulse, no o_ch_done[3].
- Abort: i_abort 3 cycles into RUN on ch0 → o_dma_abort high exactly 1 cycle, o_ch_err[0] after busy drops, next requester then granted.
- Reset: assert i_reset_n low in RUN → all outputs 0 immediately; after release, channel 0 has priority.
